// File: rtl/iterative_alu_if.sv
// Request/response bundle for iterative_alu: operands and opcode in,
// Z register pair plus handshake and status flags out.
`timescale 1ns/1ps
interface iterative_alu_if #(parameter int WIDTH = 32);
  logic             enable;
  logic             start;
  logic [4:0]       ctrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ZHI;
  logic [WIDTH-1:0] ZLO;
  logic             busy;
  logic             done;
  logic             dz;
  logic             illegal;

  modport master (output enable, start, ctrl, A, B,
                  input  ZHI, ZLO, busy, done, dz, illegal);
  modport slave  (input  enable, start, ctrl, A, B,
                  output ZHI, ZLO, busy, done, dz, illegal);
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add
// multiply and restoring divide, start/busy/done handshake.
`timescale 1ns/1ps
module iterative_alu #(
  parameter int WIDTH         = 32,
  parameter bit SIGNED_MULDIV = 1'b0
) (
  input logic            clk,
  input logic            clr,
  iterative_alu_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;

  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2;

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                         OP_DIV = 5'b00011, OP_SHR = 5'b00100, OP_SHL = 5'b00101,
                         OP_ROR = 5'b00110, OP_ROL = 5'b00111, OP_AND = 5'b01000,
                         OP_OR  = 5'b01001, OP_NEG = 5'b01010, OP_NOT = 5'b01011;

  logic [1:0]         st;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // mul: {partial hi, multiplier}; div: {remainder, dividend}
  logic [WIDTH-1:0]   opb;   // multiplicand or divisor magnitude
  logic               neg_lo, neg_hi;
  logic [WIDTH-1:0]   zhi, zlo;
  logic               busy, done, dz, illegal;

  assign bus.ZHI     = zhi;
  assign bus.ZLO     = zlo;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.dz      = dz;
  assign bus.illegal = illegal;

  // Sign-magnitude front end; in unsigned mode the sign bits are forced low.
  logic             sa, sb;
  logic [WIDTH-1:0] ma, mb;
  assign sa = SIGNED_MULDIV && bus.A[WIDTH-1];
  assign sb = SIGNED_MULDIV && bus.B[WIDTH-1];
  assign ma = sa ? -bus.A : bus.A;
  assign mb = sb ? -bus.B : bus.B;

  // Single-cycle result path, evaluated straight from the inputs at start.
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic               big;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_legal;

  assign big   = |bus.B[WIDTH-1:LW];
  assign rot_r = {bus.A, bus.A} >> bus.B[LW-1:0];
  assign rot_l = {bus.A, bus.A} << bus.B[LW-1:0];

  always_comb begin
    sc_res   = '0;
    sc_legal = 1'b1;
    case (bus.ctrl)
      OP_ADD:  sc_res = bus.A + bus.B;
      OP_SUB:  sc_res = bus.A - bus.B;
      OP_SHR:  sc_res = big ? '0 : bus.A >> bus.B[LW-1:0];
      OP_SHL:  sc_res = big ? '0 : bus.A << bus.B[LW-1:0];
      OP_ROR:  sc_res = rot_r[WIDTH-1:0];
      OP_ROL:  sc_res = rot_l[2*WIDTH-1:WIDTH];
      OP_AND:  sc_res = bus.A & bus.B;
      OP_OR:   sc_res = bus.A | bus.B;
      OP_NEG:  sc_res = ~bus.A + 1'b1;
      OP_NOT:  sc_res = ~bus.A;
      default: sc_legal = 1'b0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  logic [WIDTH:0]     madd, dtry, dsub;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    dtry = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    dsub = dtry - {1'b0, opb};
    if (st == S_MUL)
      step = {madd, acc[WIDTH-1:1]};
    else if (!dsub[WIDTH])
      step = {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      step = {dtry[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign restoration applied on the finishing edge.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  assign prod = neg_lo ? -step : step;
  assign quo  = neg_lo ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem  = neg_hi ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st      <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      zhi     <= '0;
      zlo     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
    end else if (bus.enable) begin
      done <= 1'b0;
      case (st)
        S_IDLE: if (bus.start) begin
          case (bus.ctrl)
            OP_MUL: begin
              st     <= S_MUL;
              cnt    <= CW'(WIDTH);
              acc    <= {{WIDTH{1'b0}}, mb};
              opb    <= ma;
              neg_lo <= sa ^ sb;
              busy   <= 1'b1;
            end
            OP_DIV: begin
              if (bus.B == '0) begin
                zlo     <= '1;
                zhi     <= bus.A;
                dz      <= 1'b1;
                illegal <= 1'b0;
                done    <= 1'b1;
              end else begin
                st     <= S_DIV;
                cnt    <= CW'(WIDTH);
                acc    <= {{WIDTH{1'b0}}, ma};
                opb    <= mb;
                neg_lo <= sa ^ sb;
                neg_hi <= sa;
                busy   <= 1'b1;
              end
            end
            default: begin
              // Unknown opcodes leave the Z pair untouched.
              if (sc_legal) begin
                zlo <= sc_res;
                zhi <= '0;
              end
              dz      <= 1'b0;
              illegal <= !sc_legal;
              done    <= 1'b1;
            end
          endcase
        end
        S_MUL, S_DIV: begin
          acc <= step;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            if (st == S_MUL) begin
              zhi <= prod[2*WIDTH-1:WIDTH];
              zlo <= prod[WIDTH-1:0];
            end else begin
              zhi <= rem;
              zlo <= quo;
            end
            st      <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dz      <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// Drives an unsigned and a signed iterative_alu with the same stimulus and
// compares both against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_iterative_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic         en, start;
  logic [4:0]   ctrl;
  logic [W-1:0] a, b;

  iterative_alu_if #(.WIDTH(W)) ifu ();
  iterative_alu_if #(.WIDTH(W)) ifs ();

  assign ifu.enable = en;
  assign ifu.start  = start;
  assign ifu.ctrl   = ctrl;
  assign ifu.A      = a;
  assign ifu.B      = b;
  assign ifs.enable = en;
  assign ifs.start  = start;
  assign ifs.ctrl   = ctrl;
  assign ifs.A      = a;
  assign ifs.B      = b;

  iterative_alu #(.WIDTH(W), .SIGNED_MULDIV(1'b0)) dut_u (.clk(clk), .clr(clr), .bus(ifu.slave));
  iterative_alu #(.WIDTH(W), .SIGNED_MULDIV(1'b1)) dut_s (.clk(clk), .clr(clr), .bus(ifs.slave));

  int checks = 0;
  int errors = 0;

  logic [W-1:0] eu_hi = '0, eu_lo = '0, es_hi = '0, es_lo = '0;
  bit           eu_dz = 0, eu_ill = 0, es_dz = 0, es_ill = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: results from integer arithmetic on 64-bit values.
  task automatic model(input bit sgn, input logic [4:0] op, input logic [W-1:0] x, y,
                       inout logic [W-1:0] hi, lo, output bit dz, output bit ill,
                       output int lat);
    longint sx, sy;
    logic [63:0] p, q, r;
    int amt;
    sx  = sgn ? longint'($signed(x)) : longint'(x);
    sy  = sgn ? longint'($signed(y)) : longint'(y);
    amt = int'(y % W);
    dz  = 0;
    ill = 0;
    lat = 0;
    case (op)
      5'd2: begin p = sx * sy; hi = p[63:32]; lo = p[31:0]; lat = W; end
      5'd3: begin
        if (y == 0) begin lo = '1; hi = x; dz = 1; end
        else begin q = sx / sy; r = sx % sy; lo = q[31:0]; hi = r[31:0]; lat = W; end
      end
      5'd0:  begin lo = x + y; hi = 0; end
      5'd1:  begin lo = x - y; hi = 0; end
      5'd4:  begin lo = (y >= W) ? 0 : x >> y; hi = 0; end
      5'd5:  begin lo = (y >= W) ? 0 : x << y; hi = 0; end
      5'd6:  begin lo = (x >> amt) | (x << (W - amt)); hi = 0; end
      5'd7:  begin lo = (x << amt) | (x >> (W - amt)); hi = 0; end
      5'd8:  begin lo = x & y; hi = 0; end
      5'd9:  begin lo = x | y; hi = 0; end
      5'd10: begin lo = 0 - x; hi = 0; end
      5'd11: begin lo = ~x; hi = 0; end
      default: ill = 1;
    endcase
  endtask

  // Call at a negedge with both DUTs idle; returns after edge k.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, y, output int lat);
    int l2;
    start = 1; ctrl = op; a = x; b = y;
    model(0, op, x, y, eu_hi, eu_lo, eu_dz, eu_ill, lat);
    model(1, op, x, y, es_hi, es_lo, es_dz, es_ill, l2);
    @(negedge clk);
    start = 0; ctrl = 5'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!ifu.done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_res(input string tag);
    chk({tag, "_hi_u"},   ifu.ZHI, eu_hi);
    chk({tag, "_lo_u"},   ifu.ZLO, eu_lo);
    chk({tag, "_dz_u"},   ifu.dz, eu_dz);
    chk({tag, "_ill_u"},  ifu.illegal, eu_ill);
    chk({tag, "_hi_s"},   ifs.ZHI, es_hi);
    chk({tag, "_lo_s"},   ifs.ZLO, es_lo);
    chk({tag, "_dz_s"},   ifs.dz, es_dz);
    chk({tag, "_ill_s"},  ifs.illegal, es_ill);
    chk({tag, "_done_s"}, ifs.done, 1);
    chk({tag, "_busy"},   {ifu.busy, ifs.busy}, 0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] x, y);
    int n, lat;
    issue(op, x, y, lat);
    if (lat > 0) chk({tag, "_busy_on"}, {ifu.busy, ifs.busy}, 2'b11);
    wait_done(n);
    chk({tag, "_lat"}, n, lat);
    check_res(tag);
    @(negedge clk);
    chk({tag, "_pulse"}, {ifu.done, ifs.done}, 0);
  endtask

  typedef struct { string tag; logic [4:0] op; logic [W-1:0] x, y; } vec_t;
  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, lat, seen;
    logic [W-1:0] rx, ry;
    logic [4:0]   rop;
    en = 1; start = 0; ctrl = 0; a = 0; b = 0;

    repeat (2) @(negedge clk);
    chk("rst_z", {ifu.ZHI, ifu.ZLO}, 0);
    chk("rst_flags", {ifu.busy, ifu.done, ifu.dz, ifu.illegal,
                      ifs.busy, ifs.done, ifs.dz, ifs.illegal}, 0);
    clr = 1;
    @(negedge clk);

    vecs.push_back('{"mul_ff_2",   5'd2,  32'hFFFF_FFFF, 32'd2});
    vecs.push_back('{"div_100_7",  5'd3,  32'd100,       32'd7});
    vecs.push_back('{"div_by0",    5'd3,  32'd100,       32'd0});
    vecs.push_back('{"div_m7_2",   5'd3,  -32'sd7,       32'd2});
    vecs.push_back('{"mul_m3_5",   5'd2,  -32'sd3,       32'd5});
    vecs.push_back('{"div_min_m1", 5'd3,  32'h8000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{"ror4",       5'd6,  32'h8000_0001, 32'd4});
    vecs.push_back('{"shl40",      5'd5,  32'h8000_0001, 32'd40});
    vecs.push_back('{"rol36",      5'd7,  32'h8000_0001, 32'd36});
    vecs.push_back('{"illegal",    5'd31, 32'h1234_5678, 32'd9});
    vecs.push_back('{"shr31",      5'd4,  32'h8000_0000, 32'd31});
    vecs.push_back('{"neg",        5'd10, 32'd5,         32'd0});
    vecs.push_back('{"sub_wrap",   5'd1,  32'd0,         32'd1});
    foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].op, vecs[i].x, vecs[i].y);

    // Start during busy is ignored; start in the done cycle is accepted.
    issue(5'd2, 32'd123457, 32'd99991, lat);
    repeat (4) @(negedge clk);
    start = 1; ctrl = 5'd3; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 0;
    wait_done(n);
    chk("hs_lat", n, W - 5);
    check_res("hs_mul");
    issue(5'd0, 32'hFFFF_FFF0, 32'h20, lat);
    chk("hs_add_done", ifu.done, 1);
    check_res("hs_add");
    @(negedge clk);

    // Enable stall mid-multiply stretches latency by the stalled cycles.
    issue(5'd2, 32'hDEAD_BEEF, 32'hCAFE_F00D, lat);
    repeat (4) @(negedge clk);
    en = 0;
    repeat (10) @(negedge clk);
    chk("stall_busy", {ifu.busy, ifs.busy}, 2'b11);
    en = 1;
    wait_done(n);
    chk("stall_lat", n + 14, W + 10);
    check_res("stall");
    @(negedge clk);

    // A pending done pulse holds while enable is low.
    issue(5'd8, 32'hF0F0_1234, 32'h0FF0_FFFF, lat);
    en = 0;
    repeat (2) @(negedge clk);
    chk("hold_done", {ifu.done, ifs.done}, 2'b11);
    en = 1;
    @(negedge clk);
    chk("hold_clear", {ifu.done, ifs.done}, 0);
    chk("hold_lo", ifu.ZLO, eu_lo);

    // Reset mid-divide abandons the op without a done pulse.
    issue(5'd3, 32'd1000, 32'd7, lat);
    repeat (9) @(negedge clk);
    clr = 0;
    #1;
    chk("rst_mid_z", {ifu.ZHI, ifu.ZLO, ifs.ZHI, ifs.ZLO}, 0);
    chk("rst_mid_busy", {ifu.busy, ifs.busy, ifu.done, ifs.done}, 0);
    eu_hi = 0; eu_lo = 0; es_hi = 0; es_lo = 0;
    eu_dz = 0; eu_ill = 0; es_dz = 0; es_ill = 0;
    @(negedge clk);
    clr = 1;
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (ifu.done || ifs.done) seen++;
    end
    chk("rst_nodone", seen, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 15));
      rx  = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 0;
        1:       ry = $urandom_range(0, 40);
        default: ry = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, rx, ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
